// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: data word and arbiter FSM states.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch (i*) and load/store (d*).
// Data requests win by default; a streak counter forces a fetch grant after
// MAX_DSTREAK consecutive data grants taken while a fetch was waiting.
// A watchdog aborts any access that waits TIMEOUT cycles and raises a sticky err.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              err
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic              ramren_q, ramren_d;
  logic              ramwen_q, ramwen_d;
  logic [ADDR_W-1:0] ramaddr_q, ramaddr_d;
  logic [DATA_W-1:0] ramstore_q, ramstore_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              err_q, err_d;

  logic d_req;
  logic d_grant;
  logic i_grant;
  logic busy;
  logic tmo;

  assign d_req   = dREN | dWEN;
  assign d_grant = (state_q == IDLE) && d_req && (!iREN || (streak_q < STREAK_MAX));
  assign i_grant = (state_q == IDLE) && iREN && !d_grant;
  assign busy    = (state_q != IDLE);
  assign tmo     = busy && !ram_ready && (tcnt_q == TCNT_LAST);

  // Next state, RAM command latch and sticky error
  always_comb begin
    state_d    = state_q;
    ramren_d   = ramren_q;
    ramwen_d   = ramwen_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (d_grant) begin
          // A simultaneous read+write request is serviced as a write
          state_d    = DBUSY;
          ramwen_d   = dWEN;
          ramren_d   = !dWEN;
          ramaddr_d  = daddr;
          ramstore_d = dstore;
        end else if (i_grant) begin
          state_d   = IBUSY;
          ramren_d  = 1'b1;
          ramwen_d  = 1'b0;
          ramaddr_d = iaddr;
        end
      end
      default: begin
        // Completion has priority over the watchdog on the final cycle
        if (ram_ready || tmo) begin
          state_d  = IDLE;
          ramren_d = 1'b0;
          ramwen_d = 1'b0;
        end
        if (tmo) begin
          err_d = 1'b1;
        end
      end
    endcase
  end

  // Data-grant streak: counts data grants that overtook a waiting fetch
  always_comb begin
    streak_d = streak_q;
    if (d_grant) begin
      if (!iREN) begin
        streak_d = '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + SW'(1);
      end
    end else if (i_grant) begin
      streak_d = '0;
    end
  end

  // Watchdog count of busy cycles; held at zero outside an access
  always_comb begin
    tcnt_d = tcnt_q + TW'(1);
    if (!busy || (state_d == IDLE)) begin
      tcnt_d = '0;
    end
  end

  // FSM and RAM command registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      ramren_q   <= 1'b0;
      ramwen_q   <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ramren_q   <= ramren_d;
      ramwen_q   <= ramwen_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      err_q      <= err_d;
    end
  end

  // Streak counter register
  always_ff @(posedge CLK) begin
    if (RST) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  // Timeout counter register
  always_ff @(posedge CLK) begin
    if (RST) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign iwait    = iREN  & !((state_q == IBUSY) & ram_ready);
  assign dwait    = d_req & !((state_q == DBUSY) & ram_ready);
  assign iload    = busy ? ramload : '0;
  assign dload    = busy ? ramload : '0;
  assign ramREN   = ramren_q;
  assign ramWEN   = ramwen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants and read
// data into queues, a negedge monitor pops and compares as the DUT presents them.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic        ram_ready;
  logic        err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .err(err)
  );

  always #5 CLK = ~CLK;

  // RAM model: answers ram_lat cycles after the access starts
  int ram_lat  = 0;
  bit ram_on   = 1'b1;
  int busy_cnt = 0;
  always @(posedge CLK) begin
    if ((ramREN || ramWEN) && !ram_ready) busy_cnt <= busy_cnt + 1;
    else                                  busy_cnt <= 0;
  end
  assign ram_ready = ram_on && (ramREN || ramWEN) && (busy_cnt >= ram_lat);

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (a * 32'd3 + 32'h1000_0001);
  endfunction
  assign ramload = ramREN ? rd_val(ramaddr) : 32'h0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] store;
  } grant_t;

  function automatic grant_t mk(input logic we, input logic [31:0] a, input logic [31:0] s);
    grant_t g;
    g.we = we; g.addr = a; g.store = s;
    return g;
  endfunction

  grant_t      gq[$];
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  int          gcyc[$];
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Monitor: grant order/contents, command hold, and read data on completion
  grant_t cur;
  logic   prev_en = 1'b0;
  int     cyc = 0;
  always @(negedge CLK) begin
    cyc++;
    if ((ramREN || ramWEN) && !prev_en) begin
      gcyc.push_back(cyc);
      if (gq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_grant: got grant at addr %0h, required none", ramaddr);
      end else begin
        cur = gq.pop_front();
        check("grant_wen",  ramWEN,  cur.we);
        check("grant_ren",  ramREN,  !cur.we);
        check("grant_addr", ramaddr, cur.addr);
        if (cur.we) check("grant_store", ramstore, cur.store);
      end
    end else if (ramREN || ramWEN) begin
      check("hold_addr", ramaddr, cur.addr);
      check("hold_wen",  ramWEN,  cur.we);
    end
    prev_en = ramREN || ramWEN;
    if (iREN && !iwait) begin
      if (iq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_fetch_done: got iload %0h, required no completion", iload);
      end else check("iload", iload, iq.pop_front());
    end
    if (dREN && !dWEN && !dwait) begin
      if (dq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_load_done: got dload %0h, required no completion", dload);
      end else check("dload", dload, dq.pop_front());
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Requester behaviour: hold each request until its wait drops; optionally
  // reissue further writes at consecutive addresses.
  task automatic serve(input int max_cyc, input int extra_d);
    int n = 0;
    bit id, dd;
    while ((iREN || dREN || dWEN) && (n < max_cyc)) begin
      @(negedge CLK);
      id = iREN && !iwait;
      dd = (dREN || dWEN) && !dwait;
      tick();
      n++;
      if (id) iREN = 1'b0;
      if (dd) begin
        if (extra_d > 0) begin
          daddr  = daddr + 32'd4;
          dstore = dstore + 32'd1;
          extra_d--;
        end else begin
          dREN = 1'b0;
          dWEN = 1'b0;
        end
      end
    end
    if (iREN || dREN || dWEN) begin
      checks++;
      $display("FAIL serve_bound: requests pending after %0d cycles, required completion", n);
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset state
    @(negedge CLK);
    check("rst_ramren",   ramREN,   0);
    check("rst_ramwen",   ramWEN,   0);
    check("rst_ramaddr",  ramaddr,  0);
    check("rst_ramstore", ramstore, 0);
    check("rst_err",      err,      0);
    check("rst_iwait",    iwait,    0);
    check("rst_dwait",    dwait,    0);
    check("rst_iload",    iload,    0);
    tick();

    // Fetch only
    ram_lat = 0;
    gq.push_back(mk(1'b0, 32'h40, 32'h0));
    iq.push_back(32'hDEADBEEF);
    iREN = 1'b1; iaddr = 32'h40;
    @(negedge CLK);
    check("fetch_iwait_idle", iwait, 1);
    check("fetch_iload_idle", iload, 0);
    serve(20, 0);

    // Contention: data first, then fetch after one idle cycle
    gcyc.delete();
    gq.push_back(mk(1'b0, 32'h80, 32'h0));
    gq.push_back(mk(1'b0, 32'h44, 32'h0));
    dq.push_back(32'h1000_0181);
    iq.push_back(32'h1000_00CD);
    iREN = 1'b1; iaddr = 32'h44;
    dREN = 1'b1; daddr = 32'h80;
    serve(20, 0);
    check("contention_grants", gcyc.size(), 2);
    if (gcyc.size() >= 2) check("contention_gap", gcyc[1] - gcyc[0], 2);

    // Starvation: D,D,D,D,I,D
    gq.push_back(mk(1'b1, 32'h200, 32'hA0));
    gq.push_back(mk(1'b1, 32'h204, 32'hA1));
    gq.push_back(mk(1'b1, 32'h208, 32'hA2));
    gq.push_back(mk(1'b1, 32'h20C, 32'hA3));
    gq.push_back(mk(1'b0, 32'h4C,  32'h0));
    gq.push_back(mk(1'b1, 32'h210, 32'hA4));
    iq.push_back(32'h1000_00E5);
    iREN = 1'b1; iaddr = 32'h4C;
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'hA0;
    serve(100, 4);
    check("starve_streak", dut.streak_q, 0);

    // Write held until ram_ready
    ram_lat = 3;
    gq.push_back(mk(1'b1, 32'h100, 32'h12345678));
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'h12345678;
    serve(20, 0);
    check("write_wen_after", ramWEN, 0);
    check("write_ren_after", ramREN, 0);

    // Requester drops mid-access: access still completes, wait reads 0
    ram_lat = 2;
    gq.push_back(mk(1'b0, 32'h500, 32'h0));
    dREN = 1'b1; daddr = 32'h500;
    tick();
    tick();
    dREN = 1'b0;
    @(negedge CLK);
    check("drop_dwait",     dwait,  0);
    check("drop_ren_still", ramREN, 1);
    tick(); tick(); tick();
    check("drop_ren_done",  ramREN, 0);

    // Timeout: RAM never answers
    ram_on = 1'b0;
    gq.push_back(mk(1'b0, 32'h300, 32'h0));
    dREN = 1'b1; daddr = 32'h300;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (ramREN) n++;
      else if (n > 0) break;
    end
    check("tmo_busy_cycles", n, 64);
    check("tmo_err",         err, 1);
    check("tmo_ramren",      ramREN, 0);
    check("tmo_state",       dut.state_q, IDLE);
    #1 dREN = 1'b0;
    ram_on = 1'b1;
    repeat (5) tick();
    check("tmo_err_sticky", err, 1);

    // Reset during DBUSY with a non-zero streak
    ram_lat = 10;
    gq.push_back(mk(1'b0, 32'h400, 32'h0));
    iREN = 1'b1; iaddr = 32'h48;
    dREN = 1'b1; daddr = 32'h400;
    tick();
    @(negedge CLK);
    check("rst6_busy_ren", ramREN, 1);
    check("rst6_streak_pre", dut.streak_q, 1);
    #1;
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0;
    tick();
    check("rst6_ramren",  ramREN, 0);
    check("rst6_ramwen",  ramWEN, 0);
    check("rst6_err",     err, 0);
    check("rst6_streak",  dut.streak_q, 0);
    check("rst6_state",   dut.state_q, IDLE);
    RST = 1'b0;
    repeat (3) tick();

    check("gq_empty", gq.size(), 0);
    check("iq_empty", iq.size(), 0);
    check("dq_empty", dq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
